// File: rtl/cpu_pkg.sv
// Shared fetch-side definitions: default PC vectors and the sequencer state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0040_0004;

    typedef enum logic {
        SEQ  = 1'b0,
        SLOT = 1'b1
    } pc_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target selection for J, branch and JR requests (jr > jump > branch).
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the result is consumed.
module pc_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [25:0] instr_index,
    input  logic [15:0] branch_offset,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic        jr,
    output logic [31:0] target,
    output logic        redirect,
    output logic        misaligned
);

    logic [31:0] j_target;
    logic [31:0] br_target;

    assign j_target  = {pc_plus4[31:28], instr_index, 2'b00};
    assign br_target = pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        target = pc_plus4;
        if (jr) begin
            target = jr_target;
        end else if (jump) begin
            target = j_target;
        end else if (branch_taken) begin
            target = br_target;
        end
    end

    assign redirect   = jr | jump | branch_taken;
    // A misaligned JR target is flagged but still followed; the fault is raised later.
    assign misaligned = jr & (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Owns the architectural PC; handles redirects with a MIPS delay slot, exceptions and ERET.
// Latency: redirect at cycle N -> delay slot at N+1, target at N+2.
// Backpressure: stall freezes PC/state/target; exc and eret still act under stall.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] instr_index,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        exc,
    input  logic        eret,
    input  logic [31:0] epc_in,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        in_delay_slot,
    output logic        slot_err,
    output logic        adel
);

    pc_state_t   state;
    logic [31:0] target_q;
    logic [31:0] calc_target;
    logic        calc_redirect;
    logic        calc_misaligned;

    assign pc_plus4      = pc + 32'd4;
    assign in_delay_slot = (state == SLOT);

    pc_target_calc u_target_calc (
        .pc_plus4      (pc_plus4),
        .instr_index   (instr_index),
        .branch_offset (branch_offset),
        .jr_target     (jr_target),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .jr            (jr),
        .target        (calc_target),
        .redirect      (calc_redirect),
        .misaligned    (calc_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= SEQ;
            target_q <= '0;
            slot_err <= 1'b0;
            adel     <= 1'b0;
        end else begin
            slot_err <= 1'b0;
            adel     <= 1'b0;
            if (exc) begin
                pc       <= EXC_VECTOR;
                state    <= SEQ;
                target_q <= '0;
            end else if (eret) begin
                pc       <= epc_in;
                state    <= SEQ;
                target_q <= '0;
            end else if (!stall) begin
                case (state)
                    SEQ: begin
                        pc <= pc_plus4;
                        if (calc_redirect) begin
                            target_q <= calc_target;
                            state    <= SLOT;
                            adel     <= calc_misaligned;
                        end
                    end
                    SLOT: begin
                        // Redirects decoded in the slot itself are illegal and dropped.
                        pc       <= target_q;
                        state    <= SEQ;
                        slot_err <= calc_redirect;
                    end
                    default: begin
                        pc    <= pc_plus4;
                        state <= SEQ;
                    end
                endcase
            end
        end
    end

endmodule
